// File: rtl/msu_sd_arbiter.sv
// Round-robin share of the HPS SD sector-read channel between the
// MSU audio streamer (port 0) and the MSU data-track reader (port 1).
module msu_sd_arbiter #(
  parameter int LBA_W        = 21,
  parameter int SECTOR_WORDS = 256,
  parameter int TIMEOUT      = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LBA_W-1:0] lba0,
  input  logic [LBA_W-1:0] lba1,
  output logic [1:0]       grant,
  output logic [1:0]       buff_wr_out,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             busy,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  input  logic             sd_ack,
  input  logic             sd_buff_wr
);

  localparam int WC_W = $clog2(SECTOR_WORDS) + 1;
  localparam int TM_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_grant;
  logic [1:0]       r_done;
  logic [1:0]       r_err;
  logic [LBA_W-1:0] r_lba;
  logic             r_rd;
  logic             r_last;
  logic [WC_W-1:0]  r_word;
  logic [TM_W-1:0]  r_tmo;

  logic [1:0] w_req;
  logic       w_win;
  logic       w_gate;
  logic       w_full;

  // A requester whose done/err is showing this cycle has not yet had a
  // chance to drop its level request, so it is kept out of arbitration.
  assign w_req  = req & ~(r_done | r_err);
  assign w_win  = (w_req == 2'b11) ? ~r_last : w_req[1];
  assign w_gate = (r_state == S_XFER) & sd_ack & sd_buff_wr;
  assign w_full = (r_word == WC_W'(SECTOR_WORDS));

  assign grant       = r_grant;
  assign buff_wr_out = r_grant & {2{w_gate}};
  assign done        = r_done;
  assign err         = r_err;
  assign busy        = (r_state != S_IDLE);
  assign sd_lba      = r_lba;
  assign sd_rd       = r_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_lba   <= '0;
      r_rd    <= 1'b0;
      r_last  <= 1'b1;
      r_word  <= '0;
      r_tmo   <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_grant <= w_win ? 2'b10 : 2'b01;
            r_lba   <= w_win ? lba1 : lba0;
            r_rd    <= 1'b1;
            r_last  <= w_win;
            r_tmo   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sd_ack) begin
            r_rd    <= 1'b0;
            r_word  <= '0;
            r_state <= S_XFER;
          end else if (r_tmo == TM_W'(TIMEOUT)) begin
            r_rd    <= 1'b0;
            r_err   <= r_grant;
            r_grant <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_XFER: begin
          if (w_gate && !w_full)
            r_word <= r_word + 1'b1;
          if (!sd_ack)
            r_state <= S_FIN;
        end
        S_FIN: begin
          if (w_full)
            r_done <= r_grant;
          else
            r_err  <= r_grant;
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msu_sd_arbiter.sv
// Scoreboard bench for msu_sd_arbiter: expected sector outcomes are
// queued at request time and retired when done/err appears.
module tb_msu_sd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [20:0] lba0, lba1;
  logic [1:0]  grant, buff_wr_out, done, err;
  logic        busy;
  logic [20:0] sd_lba;
  logic        sd_rd;
  logic        sd_ack, sd_buff_wr;

  always #5 clk = ~clk;

  msu_sd_arbiter #(
    .LBA_W(21), .SECTOR_WORDS(256), .TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .lba0(lba0), .lba1(lba1),
    .grant(grant), .buff_wr_out(buff_wr_out),
    .done(done), .err(err), .busy(busy),
    .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr)
  );

  typedef struct {
    int          port;
    logic [20:0] lba;
    bit          ok;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;
  int cnt0 = 0, cnt1 = 0, viol = 0, pulses = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int p, input logic [20:0] a,
                              input bit ok);
    exp_t e;
    e.port = p;
    e.lba  = a;
    e.ok   = ok;
    return e;
  endfunction

  always @(negedge clk) begin
    if (buff_wr_out[0] === 1'b1) cnt0++;
    if (buff_wr_out[1] === 1'b1) cnt1++;
    if ((buff_wr_out & ~grant) != 2'b00 || grant == 2'b11) viol++;
    pulses += $countones(done) + $countones(err);
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic sector(input int ack_dly, input int nwords,
                        input bit stray, output int lat);
    exp_t e;
    int n;
    int c0, c1;
    logic [1:0] oh;
    e  = sb[0];
    oh = (e.port == 1) ? 2'b10 : 2'b01;
    n  = 0;
    @(negedge clk);
    while (sd_rd !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    check("rd_seen", 32'(n < 200), 1);
    check("grant", 32'(grant), 32'(oh));
    check("sd_lba", 32'(sd_lba), 32'(e.lba));
    c0 = cnt0;
    c1 = cnt1;
    repeat (ack_dly) begin
      @(posedge clk); #1 sd_buff_wr = stray;
    end
    @(posedge clk); #1 sd_buff_wr = 1'b0; sd_ack = 1'b1;
    repeat (nwords) begin
      @(posedge clk); #1 sd_buff_wr = 1'b1;
    end
    @(posedge clk); #1 sd_buff_wr = 1'b0;
    @(posedge clk); #1 sd_ack = 1'b0;
    n = 0;
    @(negedge clk);
    while ((done | err) == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("end_seen", 32'(n < 20), 1);
    check("done", 32'(done), e.ok ? 32'(oh) : 0);
    check("err", 32'(err), e.ok ? 0 : 32'(oh));
    check("busy_end", 32'(busy), 0);
    check("grant_rel", 32'(grant), 0);
    check("words", e.port == 1 ? cnt1 - c1 : cnt0 - c0, nwords);
    check("other", e.port == 1 ? cnt0 - c0 : cnt1 - c1, 0);
    check("excl", viol, 0);
    void'(sb.pop_front());
  endtask

  initial begin
    int lat, n, hi, c0, c1, s0, p;
    exp_t e;
    reset = 1'b1;
    req = 2'b00;
    lba0 = '0;
    lba1 = '0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd", 32'(sd_rd), 0);
    check("rst_lba", 32'(sd_lba), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_bwr", 32'(buff_wr_out), 0);
    @(posedge clk); #1 reset = 1'b0;

    lba0 = 21'd5;
    sb.push_back(mk(0, 21'd5, 1));
    req = 2'b01;
    @(negedge clk);
    check("rd_lat0", 32'(sd_rd), 0);
    sector(3, 256, 0, lat);
    check("rd_lat1", lat, 0);
    @(posedge clk); #1 req = 2'b00;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("no_regrant", 32'(sd_rd), 0);

    do_reset();
    lba0 = 21'h12345;
    lba1 = 21'h1abcd;
    sb.push_back(mk(0, lba0, 1));
    sb.push_back(mk(1, lba1, 1));
    sb.push_back(mk(0, lba0, 1));
    sb.push_back(mk(1, lba1, 1));
    req = 2'b11;
    sector(2, 256, 0, lat);
    sector(1, 256, 0, lat);
    sector(4, 256, 0, lat);
    @(posedge clk); #1 req[0] = 1'b0;
    sector(2, 256, 0, lat);
    @(posedge clk); #1 req = 2'b00;

    sb.push_back(mk(1, lba1, 0));
    req = 2'b10;
    sector(2, 200, 0, lat);
    @(posedge clk); #1 req = 2'b00;
    sb.push_back(mk(0, lba0, 1));
    req = 2'b01;
    sector(3, 256, 0, lat);
    @(posedge clk); #1 req = 2'b00;
    sb.push_back(mk(0, lba0, 0));
    req = 2'b01;
    sector(1, 255, 0, lat);
    @(posedge clk); #1 req = 2'b00;
    sb.push_back(mk(1, lba1, 1));
    req = 2'b10;
    sector(1, 260, 0, lat);
    @(posedge clk); #1 req = 2'b00;

    sb.push_back(mk(0, lba0, 0));
    e = sb[0];
    req = 2'b01;
    n = 0;
    @(negedge clk);
    while (sd_rd !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("tmo_rd_seen", 32'(n < 10), 1);
    check("tmo_lba", 32'(sd_lba), 32'(e.lba));
    hi = 0;
    while (sd_rd === 1'b1 && hi < 300) begin
      hi++;
      @(negedge clk);
    end
    check("tmo_rd_len", hi, 101);
    check("tmo_err", 32'(err), 32'b01);
    check("tmo_done", 32'(done), 0);
    check("tmo_grant", 32'(grant), 0);
    check("tmo_busy", 32'(busy), 0);
    void'(sb.pop_front());
    @(posedge clk); #1 req = 2'b00;

    lba0 = 21'd7;
    sb.push_back(mk(0, 21'd7, 0));
    req = 2'b01;
    n = 0;
    @(negedge clk);
    while (sd_rd !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rx_rd_seen", 32'(n < 10), 1);
    s0 = cnt0;
    repeat (2) @(posedge clk);
    #1 sd_ack = 1'b1;
    repeat (100) begin
      @(posedge clk); #1 sd_buff_wr = 1'b1;
    end
    @(posedge clk); #1 reset = 1'b1; req = 2'b00;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rx_words", cnt0 - s0, 101);
    check("rx_grant", 32'(grant), 0);
    check("rx_rd", 32'(sd_rd), 0);
    check("rx_lba", 32'(sd_lba), 0);
    check("rx_busy", 32'(busy), 0);
    check("rx_bwr", 32'(buff_wr_out), 0);
    check("rx_pulse", 32'(done | err), 0);
    c0 = cnt0;
    p  = pulses;
    repeat (50) @(posedge clk);
    #1 sd_buff_wr = 1'b0; sd_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rx_no_fwd", cnt0 - c0, 0);
    check("rx_no_pulse", pulses - p, 0);
    void'(sb.pop_front());
    @(posedge clk); #1;
    sb.push_back(mk(0, lba0, 1));
    req = 2'b01;
    sector(1, 256, 0, lat);
    @(posedge clk); #1 req = 2'b00;

    c0 = cnt0;
    c1 = cnt1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 sd_buff_wr = 1'b1; sd_ack = i[0];
    end
    @(posedge clk); #1 sd_buff_wr = 1'b0; sd_ack = 1'b0;
    @(negedge clk);
    check("idle_stray", (cnt0 - c0) + (cnt1 - c1), 0);
    check("idle_stray_busy", 32'(busy), 0);
    @(posedge clk); #1;
    sb.push_back(mk(1, lba1, 1));
    req = 2'b10;
    sector(5, 256, 1, lat);
    @(posedge clk); #1 req = 2'b00;
    check("sb_empty", sb.size(), 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/msu_sd_arbiter.md
Name: msu_sd_arbiter

Overview:
- Shares the single HPS SD sector-read channel between two MSU requesters: port 0 = MSU audio streamer, port 1 = MSU data-track reader.
- Round-robin grant, one sector per grant.
- Drives sd_lba/sd_rd toward the HPS and routes sd_ack/sd_buff_wr back to the granted requester only.
- Counts transfer words, flags short or timed-out transfers, and pulses a per-requester done.

Parameters:
- LBA_W, 21, sector address width.
- SECTOR_WORDS, 256, 16-bit words per 512-byte sector.
- TIMEOUT, 65535, clk cycles allowed in WAIT_ACK before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  2  per-requester read request; level, held until done or err
- lba0  in  LBA_W  sector address, requester 0; stable while req[0]
- lba1  in  LBA_W  sector address, requester 1; stable while req[1]
- grant  out  2  one-hot, current owner of the SD channel
- buff_wr_out  out  2  sd_buff_wr gated to the granted requester
- done  out  2  1-cycle pulse, sector complete with full word count
- err  out  2  1-cycle pulse, short transfer or timeout
- busy  out  1  high in any state except IDLE
- sd_lba  out  LBA_W  to HPS
- sd_rd  out  1  to HPS, read strobe
- sd_ack  in  1  from HPS, high during transfer
- sd_buff_wr  in  1  from HPS, one pulse per word

Behaviour:
- Reset values: grant=0, buff_wr_out=0, done=0, err=0, busy=0, sd_rd=0, sd_lba=0, word_cnt=0, tmo_cnt=0, last=1 (so requester 0 wins first), state=IDLE.
- Reset mid-transfer: return to IDLE at once. No done/err pulse. Later sd_ack/sd_buff_wr from the HPS are ignored while in IDLE.
- State IDLE:
  - Pick a winner from req. If both are set, the winner is the requester that is not last. If one is set, it wins.
  - Next cycle (1-cycle latency): grant[w]=1, sd_lba=lba_w, sd_rd=1, last<=w, tmo_cnt=0, go to WAIT_ACK.
- State WAIT_ACK:
  - sd_rd stays high.
  - On sd_ack=1: sd_rd<=0, word_cnt<=0, go to XFER.
  - If tmo_cnt==TIMEOUT first: sd_rd<=0, err[w] pulse, grant<=0, go to IDLE.
  - Otherwise tmo_cnt increments.
- State XFER:
  - buff_wr_out[w] = sd_buff_wr & sd_ack. This path is combinational, with zero latency to the requester.
  - word_cnt increments on each gated write and saturates at SECTOR_WORDS.
  - When sd_ack falls, go to FINISH.
- State FINISH (1 cycle):
  - word_cnt==SECTOR_WORDS: done[w] pulse.
  - Otherwise: err[w] pulse.
  - grant<=0, go to IDLE.
  - The earliest re-grant is the cycle after FINISH, so there are at least 2 idle cycles between sd_rd pulses.
- Requests and lba are sampled only in IDLE:
  - Dropping req mid-transfer does not abort the transfer.
  - Its done/err still pulses.
  - lba changes after grant are ignored, because sd_lba is registered.
- sd_buff_wr outside XFER, or with sd_ack low, is never forwarded.
- grant is always one-hot or zero; buff_wr_out is never high for a non-granted port.
- word_cnt width is clog2(SECTOR_WORDS)+1.
- tmo_cnt width is clog2(TIMEOUT+1), with no wrap.

Test Plan:
- Single request: req=01, lba0=5. Required: sd_rd high one cycle later with sd_lba=5. HPS acks after 3 cycles and delivers 256 buff_wr pulses, then drops ack. Required: buff_wr_out[0] carries 256 pulses, then done=01 for 1 cycle, busy low.
- Contention: req=11 from reset. Required grant order 0, 1, 0, 1 over four sectors. sd_lba alternates between lba0 and lba1. buff_wr_out[1] stays 0 during every port-0 transfer.
- Short transfer: HPS drops sd_ack after 200 words. Required: err[w] pulse, no done, next grant proceeds normally.
- Timeout: TIMEOUT=100, sd_ack never asserted. Required: sd_rd high for 101 cycles, then err[0] pulse, sd_rd=0, grant=0, state IDLE.
- Reset mid-XFER at word 100: outputs return to reset values next cycle. Remaining HPS writes are not forwarded. No done/err pulse. A fresh request then completes with done.
- Stray sd_buff_wr pulses in IDLE and WAIT_ACK: buff_wr_out stays 0 and word_cnt is unaffected.
